mux4_rr_sampler: RTL and testbench

MUX4_RR_SAMPLER -- requirements
Module: mux4_rr_sampler

---
 rtl/mux4_rr_sampler.sv | 120 ++++++++++++
 tb/tb_mux4_rr_sampler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_sampler.sv
// mux4_rr_sampler: round-robin sampler driving the select lines of an external 4:1 mux.
// Ports:
//   clk_i, rst_ni      - clock and asynchronous active-low reset
//   req_i[3:0]         - per-channel sample requests (level)
//   y_i                - output of the downstream mux cell selected by s_o
//   ready_i            - consumer accepts data_o while valid_o is high
//   s_o[1:0]           - registered mux select (s_o[0] first level, s_o[1] second level)
//   gnt_o[3:0]         - registered one-hot grant of the channel being sampled
//   valid_o, data_o    - registered sample of y_i and its qualifier
//   ack_o[3:0]         - one-cycle one-hot pulse after a completed transfer
module mux4_rr_sampler (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] req_i,
    input  logic       y_i,
    input  logic       ready_i,
    output logic [1:0] s_o,
    output logic [3:0] gnt_o,
    output logic       valid_o,
    output logic       data_o,
    output logic [3:0] ack_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] s_q, s_d;
    logic [3:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;
    logic       data_q, data_d;
    logic [3:0] ack_q, ack_d;

    logic [1:0] pick_idx;
    logic       pick_vld;

    // First requesting channel scanning ptr, ptr+1, ... with 2-bit wrap.
    always_comb begin : pick_c
        logic [1:0] cand;
        cand     = '0;
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!pick_vld && req_i[cand]) begin
                pick_idx = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        s_d     = s_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        ack_d   = '0;
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_vld) begin
                    s_d     = pick_idx;
                    gnt_d   = 4'b0001 << pick_idx;
                    state_d = SETTLE;
                end
            end
            // One cycle for the mux path to settle before capturing y_i.
            SETTLE: begin
                data_d  = y_i;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    gnt_d   = '0;
                    ack_d   = gnt_q;
                    ptr_d   = s_q + 2'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            s_q     <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            s_q     <= s_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    assign s_o     = s_q;
    assign gnt_o   = gnt_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ack_o   = ack_q;

endmodule

// File: tb/tb_mux4_rr_sampler.sv
// tb_mux4_rr_sampler: directed self-checking bench for mux4_rr_sampler.
// Observed vector is {s_o, gnt_o, valid_o, data_o, ack_o}.
module tb_mux4_rr_sampler;

    logic       clk_i;
    logic       rst_ni;
    logic [3:0] req_i;
    logic       y_i;
    logic       ready_i;
    logic [1:0] s_o;
    logic [3:0] gnt_o;
    logic       valid_o;
    logic       data_o;
    logic [3:0] ack_o;

    logic       use_model;
    logic [3:0] mux_in;
    logic       y_drv;

    int n_chk;
    int n_fail;

    logic [11:0] obs;
    logic [11:0] exp_v;

    mux4_rr_sampler dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
        .y_i     (y_i),
        .ready_i (ready_i),
        .s_o     (s_o),
        .gnt_o   (gnt_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ack_o   (ack_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Behavioural 4:1 mux cell fed by s_o.
    always_comb y_i = use_model ? mux_in[s_o] : y_drv;

    assign obs = {s_o, gnt_o, valid_o, data_o, ack_o};

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req_i = 4'b1111;
        ready_i = 1'b1;
        #2;
        exp_v = 12'h000;
        n_chk++;
        if (obs !== exp_v)
            $display("FAIL reset_async obs=%h exp=%h", obs, exp_v);
        if (obs !== exp_v) n_fail++;
        step();
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_hold obs=%h exp=%h", obs, exp_v);
        end
        req_i = 4'b0000;
        #3 rst_ni = 1'b1;
    endtask

    task automatic test_basic();
        logic [11:0] tbl [6];
        tbl[0] = {2'd2, 4'b0100, 1'b0, 1'b0, 4'b0000};
        tbl[1] = {2'd2, 4'b0100, 1'b1, 1'b1, 4'b0000};
        tbl[2] = {2'd2, 4'b0000, 1'b0, 1'b1, 4'b0100};
        tbl[3] = {2'd3, 4'b1000, 1'b0, 1'b1, 4'b0000};
        tbl[4] = {2'd3, 4'b1000, 1'b1, 1'b0, 4'b0000};
        tbl[5] = {2'd3, 4'b0000, 1'b0, 1'b0, 4'b1000};
        use_model = 1'b0;
        y_drv = 1'b1;
        ready_i = 1'b1;
        req_i = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            step();
            n_chk++;
            if (obs !== tbl[k]) begin
                n_fail++;
                $display("FAIL basic_e%0d obs=%h exp=%h", k + 1, obs, tbl[k]);
            end
            if (k == 2) req_i = 4'b1111;
            if (k == 3) begin
                req_i = 4'b0000;
                y_drv = 1'b0;
            end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] ch;
        logic       d;
        logic       pd;
        use_model = 1'b1;
        mux_in = 4'b1010;
        ready_i = 1'b1;
        req_i = 4'b1111;
        pd = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ch = 2'(k % 4);
            d = mux_in[ch];
            step();
            exp_v = {ch, 4'b0001 << ch, 1'b0, pd, 4'b0000};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rr_grant%0d obs=%h exp=%h", k, obs, exp_v);
            end
            step();
            exp_v = {ch, 4'b0001 << ch, 1'b1, d, 4'b0000};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rr_valid%0d obs=%h exp=%h", k, obs, exp_v);
            end
            step();
            exp_v = {ch, 4'b0000, 1'b0, d, 4'b0001 << ch};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rr_ack%0d obs=%h exp=%h", k, obs, exp_v);
            end
            pd = d;
        end
        req_i = 4'b0000;
        step();
        exp_v = {2'd0, 4'b0000, 1'b0, 1'b0, 4'b0000};
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rr_idle obs=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_hold();
        use_model = 1'b0;
        y_drv = 1'b1;
        ready_i = 1'b0;
        req_i = 4'b0001;
        step();
        exp_v = {2'd0, 4'b0001, 1'b0, 1'b0, 4'b0000};
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL hold_grant obs=%h exp=%h", obs, exp_v);
        end
        step();
        exp_v = {2'd0, 4'b0001, 1'b1, 1'b1, 4'b0000};
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL hold_valid obs=%h exp=%h", obs, exp_v);
        end
        req_i = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            y_drv = ~y_drv;
            step();
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL hold_stall%0d obs=%h exp=%h", k, obs, exp_v);
            end
        end
        ready_i = 1'b1;
        step();
        exp_v = {2'd0, 4'b0000, 1'b0, 1'b1, 4'b0001};
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL hold_ack obs=%h exp=%h", obs, exp_v);
        end
        step();
        exp_v = {2'd0, 4'b0000, 1'b0, 1'b1, 4'b0000};
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL hold_ack_clr obs=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] tbl [9];
        tbl[0] = {2'd2, 4'b0100, 1'b0, 1'b1, 4'b0000};
        tbl[1] = {2'd2, 4'b0100, 1'b1, 1'b0, 4'b0000};
        tbl[2] = {2'd2, 4'b0000, 1'b0, 1'b0, 4'b0100};
        tbl[3] = {2'd3, 4'b1000, 1'b0, 1'b0, 4'b0000};
        tbl[4] = {2'd3, 4'b1000, 1'b1, 1'b1, 4'b0000};
        tbl[5] = {2'd3, 4'b0000, 1'b0, 1'b1, 4'b1000};
        tbl[6] = {2'd0, 4'b0001, 1'b0, 1'b1, 4'b0000};
        tbl[7] = {2'd0, 4'b0001, 1'b1, 1'b0, 4'b0000};
        tbl[8] = {2'd0, 4'b0000, 1'b0, 1'b0, 4'b0001};
        use_model = 1'b0;
        ready_i = 1'b1;
        req_i = 4'b0100;
        for (int k = 0; k < 9; k++) begin
            step();
            n_chk++;
            if (obs !== tbl[k]) begin
                n_fail++;
                $display("FAIL wrap_e%0d obs=%h exp=%h", k + 1, obs, tbl[k]);
            end
            case (k)
                0: y_drv = 1'b0;
                2: begin
                    req_i = 4'b1001;
                    y_drv = 1'b1;
                end
                3: req_i = 4'b0000;
                5: begin
                    req_i = 4'b1001;
                    y_drv = 1'b0;
                end
                8: req_i = 4'b0000;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] tbl [3];
        tbl[0] = {2'd0, 4'b0001, 1'b0, 1'b0, 4'b0000};
        tbl[1] = {2'd0, 4'b0001, 1'b1, 1'b1, 4'b0000};
        tbl[2] = {2'd0, 4'b0000, 1'b0, 1'b1, 4'b0001};
        use_model = 1'b0;
        y_drv = 1'b1;
        ready_i = 1'b0;
        req_i = 4'b0100;
        step();
        exp_v = {2'd2, 4'b0100, 1'b0, 1'b0, 4'b0000};
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rmid_grant obs=%h exp=%h", obs, exp_v);
        end
        step();
        exp_v = {2'd2, 4'b0100, 1'b1, 1'b1, 4'b0000};
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rmid_valid obs=%h exp=%h", obs, exp_v);
        end
        #3 rst_ni = 1'b0;
        #1;
        exp_v = 12'h000;
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rmid_async obs=%h exp=%h", obs, exp_v);
        end
        ready_i = 1'b1;
        step();
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rmid_no_ack obs=%h exp=%h", obs, exp_v);
        end
        req_i = 4'b0101;
        #3 rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_chk++;
            if (obs !== tbl[k]) begin
                n_fail++;
                $display("FAIL rmid_after%0d obs=%h exp=%h", k, obs, tbl[k]);
            end
        end
        req_i = 4'b0000;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_ni = 1'b0;
        req_i = 4'b0000;
        ready_i = 1'b0;
        use_model = 1'b0;
        mux_in = 4'b0000;
        y_drv = 1'b0;
        test_reset();
        test_basic();
        test_round_robin();
        test_hold();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
